// File: rtl/dma_pkg.sv
// Shared definitions for the DMA priority resolver: FSM state encoding,
// channel-count defaults and the priority-order helper functions.
package dma_pkg;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int MAX_CHANNELS     = 8;
  localparam int MAX_ORDER_W      = 24;  // MAX_CHANNELS * $clog2(MAX_CHANNELS)

  typedef enum logic [2:0] {
    SI = 3'b001,  // idle
    S0 = 3'b010,  // hold requested
    S1 = 3'b100   // channel granted
  } dma_state_t;

  // Identity order: field p holds channel p, so channel 0 is highest priority.
  function automatic logic [MAX_ORDER_W-1:0] default_order(input int channels);
    int chw;
    logic [MAX_ORDER_W-1:0] res;
    chw = $clog2(channels);
    res = '0;
    for (int p = 0; p < MAX_CHANNELS; p++) begin
      if (p < channels) begin
        res = res | (MAX_ORDER_W'(p) << (p * chw));
      end
    end
    return res;
  endfunction

  // Channel that lands in field p after channel k completes under rotation.
  function automatic int rotated_field(input int k, input int p, input int channels);
    return (k + 1 + p) % channels;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational scan of the priority order: reports the first channel,
// starting from field 0, whose pending bit is set.
module dma_priority_encoder
  import dma_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int CHW      = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]     pending,
  input  logic [CHANNELS*CHW-1:0] priorityOrder,
  output logic                    found,
  output logic [CHW-1:0]          winner
);

  logic [CHW-1:0]      field [CHANNELS];
  logic [CHANNELS-1:0] hit;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_field
      assign field[gi] = priorityOrder[gi*CHW +: CHW];
      assign hit[gi]   = pending[field[gi]];
    end
  endgenerate

  // Walk from the lowest priority upward so the last hit kept is field 0's side.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int p = CHANNELS - 1; p >= 0; p--) begin
      if (hit[p]) begin
        found  = 1'b1;
        winner = field[p];
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// 8237-style DMA request arbiter: hold request / acknowledge handshake,
// fixed or rotating channel priority, one-hot DACK while a channel is granted.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int CHW      = $clog2(CHANNELS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [CHANNELS-1:0]     DREQ,
  input  logic [CHANNELS-1:0]     requestReg,
  input  logic [CHANNELS-1:0]     maskReg,
  input  logic                    rotatingPriority,
  input  logic                    HLDA,
  input  logic                    transferDone,
  output logic                    HRQ,
  output logic [CHANNELS-1:0]     DACK,
  output logic                    grantValid,
  output logic [CHW-1:0]          grantChannel,
  output logic [CHANNELS*CHW-1:0] priorityOrder
);

  localparam logic [MAX_ORDER_W-1:0]  DEF_FULL  = default_order(CHANNELS);
  localparam logic [CHANNELS*CHW-1:0] DEF_ORDER = DEF_FULL[CHANNELS*CHW-1:0];

  dma_state_t              state_reg, state_next;
  logic [CHW-1:0]          grant_reg, grant_next;
  logic [CHANNELS*CHW-1:0] order_reg, order_next;
  logic [CHANNELS*CHW-1:0] rotated_order;
  logic [CHANNELS-1:0]     pending;
  logic                    found;
  logic [CHW-1:0]          winner;
  logic                    completion;

  // Software requests bypass the mask; hardware requests do not.
  assign pending = (DREQ & ~maskReg) | requestReg;

  dma_priority_encoder #(
    .CHANNELS(CHANNELS),
    .CHW     (CHW)
  ) u_encoder (
    .pending      (pending),
    .priorityOrder(order_reg),
    .found        (found),
    .winner       (winner)
  );

  // Order that makes the currently granted channel the lowest priority.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rotate
      assign rotated_order[gi*CHW +: CHW] =
        CHW'(rotated_field(int'(grant_reg), gi, CHANNELS));
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= SI;
      grant_reg <= '0;
      order_reg <= DEF_ORDER;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      order_reg <= order_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    order_next   = order_reg;
    completion   = 1'b0;
    HRQ          = 1'b0;
    DACK         = '0;
    grantValid   = 1'b0;
    grantChannel = '0;

    unique case (state_reg)
      SI: begin
        if (|pending) begin
          state_next = S0;
        end
      end
      S0: begin
        HRQ = 1'b1;
        if (HLDA && found) begin
          state_next = S1;
          grant_next = winner;
        end else if (!found) begin
          state_next = SI;
        end
      end
      S1: begin
        HRQ          = 1'b1;
        grantValid   = 1'b1;
        grantChannel = grant_reg;
        DACK         = CHANNELS'(1) << grant_reg;
        // A completion pulse wins over a simultaneous HLDA drop.
        if (transferDone) begin
          state_next = SI;
          completion = 1'b1;
        end else if (!HLDA) begin
          state_next = SI;
        end
      end
      default: begin
        state_next = SI;
      end
    endcase

    if (!rotatingPriority) begin
      order_next = DEF_ORDER;
    end else if (completion) begin
      order_next = rotated_order;
    end
  end

  assign priorityOrder = order_reg;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed vector table, hand-written corner sequences and randomized
// checking against a behavioural model of the DMA priority resolver.
module tb_dma_priority_resolver;

  localparam int N = 4;
  localparam logic [7:0]  E4  = 8'b11_10_01_00;
  localparam logic [7:0]  R1  = 8'b01_00_11_10;
  localparam logic [7:0]  R2  = 8'b10_01_00_11;
  localparam logic [23:0] E8  = 24'o76543210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       rst, rot, hlda, td;
  logic [3:0] dreq, req, mask;
  logic       hrq, gv;
  logic [3:0] dack;
  logic [1:0] gch;
  logic [7:0] order;

  // 8-channel instance
  logic       rst8, rot8, hlda8, td8;
  logic [7:0] dreq8, req8, mask8;
  logic       hrq8, gv8;
  logic [7:0] dack8;
  logic [2:0] gch8;
  logic [23:0] order8;

  dma_priority_resolver #(.CHANNELS(4)) dut (
    .CLK(clk), .RESET(rst), .DREQ(dreq), .requestReg(req), .maskReg(mask),
    .rotatingPriority(rot), .HLDA(hlda), .transferDone(td),
    .HRQ(hrq), .DACK(dack), .grantValid(gv), .grantChannel(gch),
    .priorityOrder(order)
  );

  dma_priority_resolver #(.CHANNELS(8)) dut8 (
    .CLK(clk), .RESET(rst8), .DREQ(dreq8), .requestReg(req8), .maskReg(mask8),
    .rotatingPriority(rot8), .HLDA(hlda8), .transferDone(td8),
    .HRQ(hrq8), .DACK(dack8), .grantValid(gv8), .grantChannel(gch8),
    .priorityOrder(order8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (4 channels) ----------------
  bit m_busy;      // hold request outstanding
  bit m_granted;   // a channel currently owns the bus
  int m_ch;        // granted channel
  int m_order[N];  // m_order[p] = channel at priority p

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_ch = 0;
    for (int p = 0; p < N; p++) m_order[p] = p;
  endtask

  function automatic logic [7:0] model_order_bits();
    logic [7:0] v = '0;
    for (int p = 0; p < N; p++) v[p*2 +: 2] = 2'(m_order[p]);
    return v;
  endfunction

  task automatic model_step(input logic [3:0] d, input logic [3:0] r, input logic [3:0] m,
                            input logic ro, input logic h, input logic t);
    logic [3:0] pend;
    int w;
    bit done;
    pend = (d & ~m) | r;
    done = 0;
    if (!m_busy) begin
      if (pend != 0) m_busy = 1;
    end else if (!m_granted) begin
      w = -1;
      for (int p = N - 1; p >= 0; p--) if (pend[m_order[p]]) w = m_order[p];
      if (w < 0) m_busy = 0;
      else if (h) begin m_granted = 1; m_ch = w; end
    end else begin
      if (t) begin done = 1; m_busy = 0; m_granted = 0; end
      else if (!h) begin m_busy = 0; m_granted = 0; end
    end
    if (!ro) begin
      for (int p = 0; p < N; p++) m_order[p] = p;
    end else if (done) begin
      for (int p = 0; p < N; p++) m_order[p] = (m_ch + 1 + p) % N;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] dreq, req, mask;
    logic       rot, hlda, td;
    logic       hrq;
    logic [3:0] dack;
    logic [7:0] order;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, E4};
    tbl[1]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, E4};
    tbl[2]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, E4};
    tbl[3]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, E4};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, E4};
    tbl[5]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, E4};
    tbl[6]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, E4};
    tbl[7]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, R1};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, R1};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, R1};
    tbl[10] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, R2};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, E4};
    tbl[12] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, E4};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, E4};
    tbl[14] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, E4};
    tbl[15] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, E4};
    tbl[16] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, E4};
    tbl[17] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, E4};
    tbl[18] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, E4};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, E4};

    rst = 1'b1; dreq = '0; req = '0; mask = '0; rot = 1'b0; hlda = 1'b0; td = 1'b0;
    rst8 = 1'b1; dreq8 = '0; req8 = '0; mask8 = '0; rot8 = 1'b0; hlda8 = 1'b0; td8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dack", 32'(dack), 32'h0);
    chk("reset_order", 32'(order), 32'(E4));
    rst = 1'b0; rst8 = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_hrq", 32'(hrq), 32'h0);
    chk("idle_dack", 32'(dack), 32'h0);
    chk("idle_order", 32'(order), 32'(E4));

    // Directed table: each row drives one cycle and checks the post-edge outputs.
    for (int i = 0; i < 20; i++) begin
      dreq = tbl[i].dreq; req = tbl[i].req; mask = tbl[i].mask;
      rot = tbl[i].rot; hlda = tbl[i].hlda; td = tbl[i].td;
      @(negedge clk);
      chk($sformatf("vec%0d_hrq", i), 32'(hrq), 32'(tbl[i].hrq));
      chk($sformatf("vec%0d_dack", i), 32'(dack), 32'(tbl[i].dack));
      chk($sformatf("vec%0d_order", i), 32'(order), 32'(tbl[i].order));
    end
    dreq = '0; req = '0; mask = '0; rot = 1'b0; hlda = 1'b0; td = 1'b0;

    // 8-channel rotating: completing ch7 restores the identity order.
    rot8 = 1'b1; dreq8 = 8'h80;
    @(negedge clk);
    chk("c8_hrq", 32'(hrq8), 32'h1);
    hlda8 = 1'b1;
    @(negedge clk);
    chk("c8_dack7", 32'(dack8), 32'h80);
    chk("c8_gch7", 32'(gch8), 32'h7);
    td8 = 1'b1;
    @(negedge clk);
    td8 = 1'b0; hlda8 = 1'b0; dreq8 = '0;
    chk("c8_release", 32'(dack8), 32'h0);
    chk("c8_field0", 32'(order8[2:0]), 32'h0);
    chk("c8_order", 32'(order8), 32'(E8));
    dreq8 = 8'h04;
    @(negedge clk);
    hlda8 = 1'b1;
    @(negedge clk);
    chk("c8_dack2", 32'(dack8), 32'h04);
    // Asynchronous reset mid-grant, well before the next rising edge.
    #2 rst8 = 1'b1;
    #1;
    chk("c8_async_dack", 32'(dack8), 32'h0);
    chk("c8_async_hrq", 32'(hrq8), 32'h0);
    chk("c8_async_gv", 32'(gv8), 32'h0);
    @(negedge clk);
    rst8 = 1'b0; hlda8 = 1'b0; dreq8 = '0;
    @(negedge clk);
    chk("c8_post_reset_order", 32'(order8), 32'(E8));
    chk("c8_post_reset_hrq", 32'(hrq8), 32'h0);

    // Randomized run against the behavioural model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      chk("rnd_hrq", 32'(hrq), 32'(m_busy));
      chk("rnd_gv", 32'(gv), 32'(m_granted));
      chk("rnd_dack", 32'(dack), m_granted ? 32'(1 << m_ch) : 32'h0);
      chk("rnd_gch", 32'(gch), m_granted ? 32'(m_ch) : 32'h0);
      chk("rnd_order", 32'(order), 32'(model_order_bits()));
      dreq = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(0, 15));
      mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req  = ($urandom_range(0, 9) < 8) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rot = ~rot;
      hlda = ($urandom_range(0, 9) < 6);
      td   = ($urandom_range(0, 9) < 2);
      model_step(dreq, req, mask, rot, hlda, td);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_priority_resolver.md
DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

Interface
REQ-001 Parameter CHANNELS, default 4, number of DMA channels; legal range 2..8.
REQ-002 Parameter CHW, default $clog2(CHANNELS), channel-index width; derived, never overridden.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-high.
REQ-005 DREQ  input  CHANNELS  hardware requests, active-high, level-sensitive.
REQ-006 requestReg  input  CHANNELS  software requests, active-high.
REQ-007 maskReg  input  CHANNELS  1 = channel hardware request masked; does not mask requestReg.
REQ-008 rotatingPriority  input  1  1 = rotating priority, 0 = fixed priority.
REQ-009 HLDA  input  1  hold acknowledge from bus owner.
REQ-010 transferDone  input  1  one-cycle pulse from timing control: granted service complete.
REQ-011 HRQ  output  1  hold request.
REQ-012 DACK  output  CHANNELS  one-hot acknowledge, active-high.
REQ-013 grantValid  output  1  high while a channel is granted.
REQ-014 grantChannel  output  CHW  index of granted channel; 0 when grantValid low.
REQ-015 priorityOrder  output  CHANNELS*CHW  field p holds the channel at priority p; field 0 is highest.

Function
REQ-016 pending[i] = (DREQ[i] & ~maskReg[i]) | requestReg[i], evaluated combinationally every cycle.
REQ-017 FSM states SI (idle), S0 (hold requested), S1 (granted), registered, one-hot encoded.
REQ-018 SI: any pending bit set -> S0 next edge; HRQ high from that edge.
REQ-019 S0: all pending clear and HLDA low -> SI, HRQ low next edge (request withdrawn).
REQ-020 S0: HLDA high -> S1; winner = first channel in priorityOrder, scanning field 0 upward, with pending set; winner sampled on that same edge.
REQ-021 S1: DACK[winner] = 1, grantValid = 1, grantChannel = winner, HRQ = 1; all held stable; no preemption by higher-priority requests or mask changes.
REQ-022 S1: transferDone high -> SI next edge; DACK, grantValid, HRQ low from that edge.
REQ-023 S1: HLDA low without transferDone -> SI next edge (abort); priorityOrder unchanged.
REQ-024 transferDone and HLDA falling in the same cycle are treated as completion (REQ-022, REQ-025).
REQ-025 Rotating mode, on completion of channel k: field p becomes channel (k+1+p) mod CHANNELS, so k is lowest priority; order updates on the same edge as exit from S1.
REQ-026 rotatingPriority low: priorityOrder forced to default (field p = p) on the next edge, including mid-grant; grant unaffected.
REQ-027 Latency: request to HRQ = 1 cycle; HLDA to DACK = 1 cycle; transferDone to DACK release = 1 cycle.
REQ-028 At most one DACK bit set in any cycle; DACK is zero outside S1.
REQ-029 Re-entry: pending still set in SI after completion -> S0 on the following edge (minimum one idle cycle between grants).
REQ-030 transferDone or HLDA outside the states named above are ignored.

Reset
REQ-031 RESET high: state = SI, HRQ = 0, DACK = 0, grantValid = 0, grantChannel = 0, priorityOrder = default (CHANNELS=4: 8'b11_10_01_00), asynchronously.
REQ-032 Reset mid-grant drops DACK immediately, with no rotation; first request after release takes the REQ-018 path.

Structure
REQ-033 dma_pkg holds the state one-hot constants (SI, S0, S1), the default CHANNELS value, and a default-order function taking CHANNELS.
REQ-034 One combinational sub-module, dma_priority_encoder (inputs pending and priorityOrder; outputs found and winner), is instantiated once.

Verification
REQ-035 Reset, then idle 5 cycles -> HRQ=0, DACK=4'b0000, priorityOrder=8'b11_10_01_00.
REQ-036 Fixed mode: DREQ=4'b1010, HLDA raised 2 cycles later -> DACK=4'b0010 one cycle after HLDA; transferDone -> DACK=0 next cycle; order unchanged.
REQ-037 Rotating mode: complete ch1, then DREQ=4'b1111 -> order 8'b01_00_11_10 and next grant DACK=4'b0100.
REQ-038 Masking: maskReg=4'b0001, DREQ=4'b0001, requestReg=0 -> HRQ stays 0; then set requestReg=4'b0001 -> HRQ=1 next cycle.
REQ-039 Abort: in S1 on ch3, HLDA drops without transferDone -> DACK=0 next cycle; order unchanged.
REQ-040 CHANNELS=8, rotating: complete ch7 -> order field 0 = 0; assert RESET mid-grant -> DACK=0 immediately.
